// File: rtl/traffic_gen_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_gen_scheduler
//
// Purpose: issues a stream of indexed requests over a valid/ready
// interface.  Requests are sent in ACTIVE windows separated by GAP periods.
// The request count, window length and gap length are latched on start.
//
// Optional feature macro: TRAFFIC_GEN_SCHEDULER_STALL_CNT_EN
//   defined   -> stall_cnt_o counts ACTIVE cycles with valid_o=1, ready_i=0
//                (saturating at all-ones)
//   undefined -> no stall counter logic; stall_cnt_o is tied to 0
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   clear_i        synchronous soft clear / abort
//   start_i        start pulse, honoured only in IDLE
//   n_total_reqs_i total requests to issue
//   t_ck_reqs_i    ACTIVE window length in cycles (0 treated as 1)
//   t_ck_idle_i    GAP length in cycles
//   valid_o        request valid
//   ready_i        request ready
//   data_o         0-based index of the current request
//   cnt_issued_o   handshakes completed
//   stall_cnt_o    stalled ACTIVE cycles (see macro above)
//   idle_o/busy_o/done_o  status flags
// ---------------------------------------------------------------------------
module traffic_gen_scheduler #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] n_total_reqs_i,
    input  logic [CNT_W-1:0] t_ck_reqs_i,
    input  logic [CNT_W-1:0] t_ck_idle_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] data_o,
    output logic [CNT_W-1:0] cnt_issued_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             idle_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_n_total;
    logic [CNT_W-1:0] r_t_reqs;
    logic [CNT_W-1:0] r_t_idle;
    logic [CNT_W-1:0] r_cnt_issued;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_gap_cnt;

    logic             w_hs;
    logic [CNT_W-1:0] w_t_reqs_eff;
    logic             w_win_expired;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_hs          = (r_state == S_ACTIVE) && ready_i;
    // A zero-length window behaves as a one-cycle window.
    assign w_t_reqs_eff  = (r_t_reqs == '0) ? CNT_W'(1) : r_t_reqs;
    assign w_win_expired = (r_win_cnt >= (w_t_reqs_eff - CNT_W'(1)));
    assign w_cnt_next    = r_cnt_issued + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_n_total    <= '0;
            r_t_reqs     <= '0;
            r_t_idle     <= '0;
            r_cnt_issued <= '0;
            r_win_cnt    <= '0;
            r_gap_cnt    <= '0;
        end else if (clear_i) begin
            r_state      <= S_IDLE;
            r_cnt_issued <= '0;
            r_win_cnt    <= '0;
            r_gap_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_n_total    <= n_total_reqs_i;
                        r_t_reqs     <= t_ck_reqs_i;
                        r_t_idle     <= t_ck_idle_i;
                        r_cnt_issued <= '0;
                        r_win_cnt    <= '0;
                        r_state      <= (n_total_reqs_i == '0) ? S_DONE : S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_hs) begin
                        r_cnt_issued <= w_cnt_next;
                        if (w_cnt_next == r_n_total) begin
                            r_state <= S_DONE;
                        end else if (w_win_expired && (r_t_idle != '0)) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= '0;
                        end else if (w_win_expired) begin
                            // No gap configured: open a fresh window at once.
                            r_win_cnt <= '0;
                        end else begin
                            r_win_cnt <= r_win_cnt + CNT_W'(1);
                        end
                    end else if (r_win_cnt != '1) begin
                        // Saturate so a very long stall cannot un-expire the window.
                        r_win_cnt <= r_win_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == (r_t_idle - CNT_W'(1))) begin
                        r_state   <= S_ACTIVE;
                        r_win_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TRAFFIC_GEN_SCHEDULER_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_ACTIVE) && !ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

    assign valid_o      = (r_state == S_ACTIVE);
    assign data_o       = r_cnt_issued;
    assign cnt_issued_o = r_cnt_issued;
    assign idle_o       = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);

endmodule

// File: doc/traffic_gen_scheduler.md
TRAFFIC_GEN_SCHEDULER -- requirements
Module: traffic_gen_scheduler

Interface
REQ-001 Parameter CNT_W, default 32: width of all count/config fields.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 clear_i  input  1  synchronous soft clear/abort.
REQ-005 start_i  input  1  start pulse; sampled only in IDLE.
REQ-006 n_total_reqs_i  input  CNT_W  total requests to issue.
REQ-007 t_ck_reqs_i  input  CNT_W  ACTIVE window length in cycles.
REQ-008 t_ck_idle_i  input  CNT_W  GAP length in cycles.
REQ-009 valid_o  output  1  request stream valid.
REQ-010 ready_i  input  1  request stream ready.
REQ-011 data_o  output  CNT_W  index of the current request (0-based).
REQ-012 cnt_issued_o  output  CNT_W  number of handshakes completed.
REQ-013 stall_cnt_o  output  CNT_W  ACTIVE cycles with valid_o=1 and ready_i=0.
REQ-014 idle_o, busy_o, done_o  output  1 each  status flags.

Function
REQ-015 FSM states: IDLE, ACTIVE, GAP, DONE.
REQ-016 IDLE: valid_o=0, idle_o=1, busy_o=0. On start_i, latch all three config inputs. Go to DONE if n_total_reqs_i==0; otherwise go to ACTIVE.
REQ-017 Config inputs are used only through the latched copies; changes to the inputs while busy have no effect.
REQ-018 ACTIVE: valid_o=1 and data_o=cnt_issued_o; valid_o is asserted the cycle after start_i.
REQ-019 Handshake is valid_o & ready_i; each handshake increments cnt_issued_o by 1.
REQ-020 Window counter: reset on entry to ACTIVE; incremented every ACTIVE cycle regardless of ready_i.
REQ-021 A latched t_ck_reqs of 0 is treated as 1.
REQ-022 Window expired = window counter >= t_ck_reqs-1.
REQ-023 Once asserted, valid_o is never deasserted and data_o never changes until a handshake occurs.
REQ-024 ACTIVE exits only on a handshake cycle:
- to DONE if the new cnt_issued equals n_total;
- else to GAP if the window has expired and t_ck_idle>0;
- else, if the window has expired and t_ck_idle==0, stay in ACTIVE with the window counter reset;
- otherwise stay in ACTIVE.
REQ-025 An expired window with no handshake keeps the FSM in ACTIVE, valid held, until a handshake occurs.
REQ-026 GAP: valid_o=0; lasts exactly t_ck_idle cycles, then goes to ACTIVE.
REQ-027 DONE: valid_o=0; done_o=1 for exactly one cycle; next state is IDLE.
REQ-028 busy_o=1 in ACTIVE, GAP and DONE.
REQ-029 cnt_issued_o holds its final value in IDLE until the next start_i or clear_i.
REQ-030 start_i zeroes cnt_issued_o and stall_cnt_o.
REQ-031 start_i outside IDLE is ignored.
REQ-032 All counters are unsigned CNT_W wide; the stall counter saturates at all-ones and does not wrap.
REQ-033 clear_i in any state:
- next state IDLE; valid_o=0 next cycle; counters zeroed; done_o not asserted;
- clear_i has priority over start_i and over a handshake in the same cycle;
- mid-request abort is permitted.

Reset
REQ-034 rst_i=1 at a clock edge forces:
- state IDLE;
- valid_o=0, done_o=0, busy_o=0, idle_o=1;
- data_o, cnt_issued_o and stall_cnt_o = 0;
- latched config = 0.
REQ-035 Reset has priority over clear_i and start_i and aborts any operation in progress.

Configuration
REQ-036 Macro TRAFFIC_GEN_SCHEDULER_STALL_CNT_EN. Defined: stall counter implemented per REQ-013/REQ-032. Undefined: no stall counter logic is present and stall_cnt_o is constant 0. All other behaviour is identical in both cases.

Verification
REQ-037 n_total=5, t_reqs=2, t_idle=3, ready=1, start at cycle 0 -> handshakes at cycles 1,2,6,7,11 with data 0..4; done_o at cycle 12; idle_o at cycle 13; cnt_issued=5.
REQ-038 n_total=2, t_reqs=1, t_idle=0, ready low in cycles 1-4 -> valid_o=1 and data_o=0 stable in cycles 1-4; handshakes at cycles 5,6; done_o at 7; stall_cnt_o=4 with macro defined, 0 without.
REQ-039 n_total=0 with start at cycle 0 -> valid_o never asserted; done_o at cycle 1; cnt_issued=0.
REQ-040 n_total=10, t_reqs=3, t_idle=5, clear_i during the GAP -> valid_o=0; idle_o=1 and counters 0 next cycle; no done_o; a subsequent start runs a full sequence normally.
REQ-041 rst_i asserted mid-ACTIVE together with start_i -> state IDLE and outputs at reset values next cycle; start_i ignored.
REQ-042 start_i re-pulsed during ACTIVE and config inputs changed mid-run -> no effect; the sequence completes with the originally latched values.
